// File: rtl/step3.sv
// step3: per-point argmax over NACT candidate alpha vectors using one shared dot-product datapath
module step3 #(
    parameter int NPT  = 16,
    parameter int NACT = 3,
    parameter int W    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic [0:NACT-1][0:NPT-1][0:1][W-1:0]   gamma_action_belief,
    input  logic [0:NPT-1][0:1][W-1:0]             point_belief,
    output logic [0:NPT-1][0:1][W-1:0]             alpha_new,
    output logic [0:NPT-1][1:0]                    best_action,
    output logic [0:NPT-1][W-1:0]                  best_value,
    output logic                                   busy,
    output logic                                   done
);
    localparam int PW = NPT > 1 ? $clog2(NPT) : 1;
    localparam int AW = NACT > 1 ? $clog2(NACT) : 1;
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
    state_t                               state_q;
    logic [0:NACT-1][0:NPT-1][0:1][W-1:0] g_q;
    logic [0:NPT-1][0:1][W-1:0]           b_q;
    logic [PW-1:0]                        pt_q;
    logic [AW-1:0]                        act_q, ba_q, win_a;
    logic [W-1:0]                         bv_q, dot, win_v;
    logic [2*W-1:0]                       sum;
    logic                                 take, last_act, last_pt;
    always_comb begin
        sum      = (2*W)'(g_q[act_q][pt_q][0]) * (2*W)'(b_q[pt_q][0])
                 + (2*W)'(g_q[act_q][pt_q][1]) * (2*W)'(b_q[pt_q][1]);
        dot      = sum[2*W-1:W];
        take     = (act_q == '0) || (dot > bv_q);
        win_a    = take ? act_q : ba_q;
        win_v    = take ? dot : bv_q;
        last_act = act_q == AW'(NACT - 1);
        last_pt  = pt_q == PW'(NPT - 1);
    end
    always_ff @(posedge clk)
        if (state_q == IDLE && en && !rst) begin
            g_q <= gamma_action_belief;
            b_q <= point_belief;
        end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            pt_q        <= '0;
            act_q       <= '0;
            bv_q        <= '0;
            ba_q        <= '0;
            alpha_new   <= '0;
            best_action <= '0;
            best_value  <= '0;
        end else begin
            case (state_q)
                IDLE: if (en) begin
                    pt_q    <= '0;
                    act_q   <= '0;
                    busy    <= 1'b1;
                    state_q <= EVAL;
                end
                EVAL: begin
                    bv_q <= win_v;
                    ba_q <= win_a;
                    if (last_act) begin
                        alpha_new[pt_q]   <= g_q[win_a][pt_q];
                        best_action[pt_q] <= 2'(win_a);
                        best_value[pt_q]  <= win_v;
                        act_q             <= '0;
                        pt_q              <= pt_q + 1'b1;
                        if (last_pt) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        act_q <= act_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_step3.sv
// tb_step3: table-driven directed check of step3 plus capture, reset and back-to-back sequences
module tb_step3;
    localparam int NPT = 16, NACT = 3, W = 16;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic [0:NACT-1][0:NPT-1][0:1][W-1:0] gamma_action_belief = '0;
    logic [0:NPT-1][0:1][W-1:0]           point_belief = '0;
    logic [0:NPT-1][0:1][W-1:0]           alpha_new;
    logic [0:NPT-1][1:0]                  best_action;
    logic [0:NPT-1][W-1:0]                best_value;
    logic                                 busy, done;
    step3 #(.NPT(NPT), .NACT(NACT), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en),
        .gamma_action_belief(gamma_action_belief), .point_belief(point_belief),
        .alpha_new(alpha_new), .best_action(best_action), .best_value(best_value),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [2:0][1:0][15:0] g;
        logic [1:0][15:0]      b;
        logic [1:0]            act;
        logic [15:0]           val;
        logic [15:0]           a0, a1;
    } vec_t;
    vec_t tv[6];
    int n_vec = 0, n_bad = 0;
    function automatic vec_t mk(input logic [15:0] g00, g01, g10, g11, g20, g21, b0, b1,
                                input logic [1:0] act, input logic [15:0] val, a0, a1);
        vec_t v;
        v.g[0][0] = g00; v.g[0][1] = g01;
        v.g[1][0] = g10; v.g[1][1] = g11;
        v.g[2][0] = g20; v.g[2][1] = g21;
        v.b[0] = b0; v.b[1] = b1;
        v.act = act; v.val = val; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic load(input int t);
        for (int i = 0; i < NPT; i++) begin
            for (int a = 0; a < NACT; a++) begin
                gamma_action_belief[a][i][0] = tv[t].g[a][0];
                gamma_action_belief[a][i][1] = tv[t].g[a][1];
            end
            point_belief[i][0] = tv[t].b[0];
            point_belief[i][1] = tv[t].b[1];
        end
    endtask
    task automatic check_res(input int t, input string nm);
        for (int i = 0; i < NPT; i++)
            chk($sformatf("%s pt%0d act/val/alpha", nm, i),
                {best_action[i], best_value[i], alpha_new[i][0], alpha_new[i][1]},
                {tv[t].act, tv[t].val, tv[t].a0, tv[t].a1});
    endtask
    task automatic run(input int t);
        int first;
        first = 0;
        load(t);
        en = 1'b1;
        tick;
        en = 1'b0;
        chk($sformatf("vec%0d busy after start", t), 64'(busy), 64'd1);
        for (int k = 1; k <= 100; k++) begin
            tick;
            if (done) begin
                first = k;
                break;
            end
        end
        chk($sformatf("vec%0d done latency", t), 64'(first + 1), 64'd49);
        en = 1'b1;
        check_res(t, $sformatf("vec%0d", t));
        tick;
        en = 1'b0;
        chk($sformatf("vec%0d idle after done {busy,done}", t), 64'({busy, done}), 64'd0);
    endtask
    initial begin
        int first, dn;
        tv[0] = mk(16'h1000, 0, 16'h2000, 0, 16'h3000, 0, 16'h8000, 16'h8000, 2, 16'h1800, 16'h3000, 0);
        tv[1] = mk(16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h8000, 16'h8000,
                   0, 16'h4000, 16'h4000, 16'h4000);
        tv[2] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'hFFFF, 0);
        tv[3] = mk(16'h3000, 0, 16'h2000, 0, 16'h1000, 0, 16'h8000, 16'h8000, 0, 16'h1800, 16'h3000, 0);
        tv[4] = mk(16'hFFFF, 16'h1000, 0, 16'h2000, 16'hFFFF, 16'h1FFF, 0, 16'hFFFF, 1, 16'h1FFF, 0, 16'h2000);
        tv[5] = mk(0, 0, 16'h4000, 0, 0, 16'h4000, 16'h8000, 16'h8000, 1, 16'h2000, 16'h4000, 0);
        tick;
        tick;
        chk("reset state", 64'({busy, done, |alpha_new, |best_action, |best_value}), 64'd0);
        rst = 1'b0;
        for (int t = 0; t < 6; t++) run(t);
        first = 0;
        dn = 0;
        load(0);
        en = 1'b1;
        tick;
        en = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            if (k == 5) load(1);
            en = (k == 10);
            tick;
            if (done) begin
                dn++;
                if (first == 0) first = k;
            end
        end
        en = 1'b0;
        chk("capture done latency", 64'(first + 1), 64'd49);
        chk("capture done count", 64'(dn), 64'd1);
        check_res(0, "capture");
        load(2);
        en = 1'b1;
        tick;
        en = 1'b0;
        for (int k = 1; k < 20; k++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrun reset clears", 64'({busy, done, |alpha_new, |best_action, |best_value}), 64'd0);
        dn = 0;
        for (int k = 0; k < 100; k++) begin
            tick;
            if (done || busy) dn++;
        end
        chk("no activity after reset", 64'(dn), 64'd0);
        run(3);
        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
